// File: rtl/etc_fetch_addr_unit.sv
// ETC2 block fetcher and texel address generator: walks 4x4 blocks in raster order,
// serves 16 texels per block and emits each texel's 32bpp framebuffer byte address.
module etc_fetch_addr_unit #(
  parameter int BLOCKS_X   = 32,
  parameter int BLOCKS_Y   = 32,
  parameter int BLK_ADDR_W = 16
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  write_finish,
  input  logic [31:0]           width,
  output logic                  blk_rd_en,
  output logic [BLK_ADDR_W-1:0] blk_rd_addr,
  input  logic [63:0]           blk_rd_data,
  output logic [63:0]           block_out,
  output logic [7:0]            blockX_out,
  output logic [7:0]            blockY_out,
  output logic [4:0]            pixIdx_out,
  output logic                  valid,
  output logic                  image_finished,
  output logic [31:0]           out_addr,
  output logic                  addr_valid
);

  typedef enum logic [1:0] {FETCH, WAIT, SERVE, DONE} state_e;

  localparam logic [7:0] LAST_X = 8'(BLOCKS_X - 1);
  localparam logic [7:0] LAST_Y = 8'(BLOCKS_Y - 1);

  state_e      state_q, state_d;
  logic        run_q;
  logic [7:0]  blk_x_q, blk_y_q;
  logic [3:0]  pix_q;
  logic [63:0] block_q;
  logic [31:0] addr_q;
  logic        addr_valid_q;

  logic        accept, last_pix, last_col, last_blk;
  logic [31:0] y_px, x_px, pix_addr;

  assign accept   = (state_q == SERVE) && write_finish;
  assign last_pix = (pix_q == 4'hF);
  assign last_col = (blk_x_q == LAST_X);
  assign last_blk = last_col && (blk_y_q == LAST_Y);

  // run_q holds the first FETCH for one cycle after reset release so the
  // read strobe stays low while reset is asserted.
  always_ff @(posedge sclk) begin
    if (!rst) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (run_q) state_d = WAIT;
      WAIT:    state_d = SERVE;
      SERVE:   if (accept && last_pix) state_d = last_blk ? DONE : FETCH;
      DONE:    state_d = DONE;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    blk_rd_en      = run_q && (state_q == FETCH);
    valid          = (state_q == SERVE);
    image_finished = (state_q == DONE);
  end

  always_ff @(posedge sclk) begin
    if (!rst) begin
      blk_x_q <= '0;
      blk_y_q <= '0;
      pix_q   <= '0;
      block_q <= '0;
    end else begin
      if (state_q == WAIT) block_q <= blk_rd_data;
      if (accept) begin
        pix_q <= pix_q + 4'd1;
        if (last_pix && !last_blk) begin
          if (last_col) begin
            blk_x_q <= '0;
            blk_y_q <= blk_y_q + 8'd1;
          end else begin
            blk_x_q <= blk_x_q + 8'd1;
          end
        end
      end
    end
  end

  // Column-major texel layout: pix[3:2] is the column, pix[1:0] the row.
  assign y_px     = {22'd0, blk_y_q, pix_q[1:0]};
  assign x_px     = {22'd0, blk_x_q, pix_q[3:2]};
  assign pix_addr = (y_px * width + x_px) << 2;

  always_ff @(posedge sclk) begin
    if (!rst) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      addr_valid_q <= valid;
      if (valid) addr_q <= pix_addr;
    end
  end

  assign blk_rd_addr = BLK_ADDR_W'(32'(blk_y_q) * 32'(BLOCKS_X) + 32'(blk_x_q));
  assign block_out   = block_q;
  assign blockX_out  = blk_x_q;
  assign blockY_out  = blk_y_q;
  assign pixIdx_out  = {1'b0, pix_q};
  assign out_addr    = addr_q;
  assign addr_valid  = addr_valid_q;

endmodule

// File: tb/tb_etc_fetch_addr_unit.sv
// Bench for etc_fetch_addr_unit: a 32x32 instance under directed/random write_finish and
// a 2x2 instance with write_finish tied high, both checked against a texel-stream model.
module tb_etc_fetch_addr_unit;

  logic        sclk, rst, wf;
  logic [31:0] width;
  logic [63:0] mem [1024];

  logic        b_en, b_valid, b_fin, b_av;
  logic [15:0] b_rd_addr;
  logic [63:0] b_rd_data, b_blk;
  logic [7:0]  b_bx, b_by;
  logic [4:0]  b_pix;
  logic [31:0] b_oaddr;

  logic        s_en, s_valid, s_fin, s_av;
  logic [15:0] s_rd_addr;
  logic [63:0] s_rd_data, s_blk;
  logic [7:0]  s_bx, s_by;
  logic [4:0]  s_pix;
  logic [31:0] s_oaddr;

  int n_err = 0;
  int n_chk = 0;

  etc_fetch_addr_unit #(.BLOCKS_X(32), .BLOCKS_Y(32), .BLK_ADDR_W(16)) u_big (
    .sclk(sclk), .rst(rst), .write_finish(wf), .width(width),
    .blk_rd_en(b_en), .blk_rd_addr(b_rd_addr), .blk_rd_data(b_rd_data),
    .block_out(b_blk), .blockX_out(b_bx), .blockY_out(b_by), .pixIdx_out(b_pix),
    .valid(b_valid), .image_finished(b_fin), .out_addr(b_oaddr), .addr_valid(b_av));

  etc_fetch_addr_unit #(.BLOCKS_X(2), .BLOCKS_Y(2), .BLK_ADDR_W(16)) u_small (
    .sclk(sclk), .rst(rst), .write_finish(1'b1), .width(width),
    .blk_rd_en(s_en), .blk_rd_addr(s_rd_addr), .blk_rd_data(s_rd_data),
    .block_out(s_blk), .blockX_out(s_bx), .blockY_out(s_by), .pixIdx_out(s_pix),
    .valid(s_valid), .image_finished(s_fin), .out_addr(s_oaddr), .addr_valid(s_av));

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // Synchronous block memory: data one cycle after the read strobe.
  always @(posedge sclk) begin
    if (b_en) b_rd_data <= mem[b_rd_addr[9:0]];
    if (s_en) s_rd_data <= mem[s_rd_addr[9:0]];
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: the image is a stream of texels n = 0 .. BX*BY*16-1.
  function automatic logic [31:0] ref_addr(int n, int bxn, logic [31:0] w);
    int b   = n / 16;
    int p   = n % 16;
    logic [31:0] y = 32'((b / bxn) * 4 + (p % 4));
    logic [31:0] x = 32'((b % bxn) * 4 + (p / 4));
    return (y * w + x) * 32'd4;
  endfunction

  int          m_n[2], m_gap[2];
  bit          m_done[2], m_post[2], m_av[2];
  logic [31:0] m_addr[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0; m_gap[d] = 3; m_done[d] = 0; m_post[d] = 1; m_av[d] = 0; m_addr[d] = '0;
    end
  end

  task automatic model_cycle(input int d, input int bxn, input int byn,
                             input logic en, input logic [15:0] rda, input logic [63:0] blk,
                             input logic [7:0] bx, input logic [7:0] by, input logic [4:0] pix,
                             input logic vld, input logic fin, input logic [31:0] oa,
                             input logic av, input logic wfv, input logic rstv);
    bit ev = !m_done[d] && m_gap[d] == 0;
    bit ee = !m_done[d] && m_gap[d] == 2;
    int b  = m_n[d] / 16;
    check_eq($sformatf("d%0d_valid", d), vld, ev);
    check_eq($sformatf("d%0d_rd_en", d), en, ee);
    if (ee) check_eq($sformatf("d%0d_rd_addr", d), rda, b);
    check_eq($sformatf("d%0d_fin", d), fin, m_done[d]);
    check_eq($sformatf("d%0d_addr_valid", d), av, m_av[d]);
    check_eq($sformatf("d%0d_out_addr", d), oa, m_addr[d]);
    if (ev) begin
      check_eq($sformatf("d%0d_bx", d), bx, b % bxn);
      check_eq($sformatf("d%0d_by", d), by, b / bxn);
      check_eq($sformatf("d%0d_pix", d), pix, m_n[d] % 16);
      check_eq($sformatf("d%0d_block", d), blk, mem[b]);
    end
    if (m_post[d]) begin
      check_eq($sformatf("d%0d_rst_outs", d), {blk, bx, by, pix, rda}, '0);
    end
    if (!rstv) begin
      m_n[d] = 0; m_gap[d] = 3; m_done[d] = 0; m_post[d] = 1; m_av[d] = 0; m_addr[d] = '0;
    end else begin
      m_post[d] = 0;
      m_av[d]   = ev;
      if (ev) m_addr[d] = ref_addr(m_n[d], bxn, width);
      if (ev && wfv) begin
        m_n[d]++;
        if (m_n[d] % 16 == 0) begin
          if (m_n[d] == bxn * byn * 16) m_done[d] = 1;
          else m_gap[d] = 2;
        end
      end else if (m_gap[d] > 0 && !m_done[d]) begin
        m_gap[d]--;
      end
    end
  endtask

  always @(negedge sclk) begin
    model_cycle(0, 32, 32, b_en, b_rd_addr, b_blk, b_bx, b_by, b_pix,
                b_valid, b_fin, b_oaddr, b_av, wf, rst);
    model_cycle(1, 2, 2, s_en, s_rd_addr, s_blk, s_bx, s_by, s_pix,
                s_valid, s_fin, s_oaddr, s_av, 1'b1, rst);
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  logic [31:0] spec_addr;
  logic [15:0] last_rd;
  bit          found;

  initial begin
    wf = 1'b0; rst = 1'b0; width = 32'd128;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    repeat (3) tick();
    rst = 1'b1;

    // First block: FETCH, WAIT, SERVE, then the first address
    tick();
    check_eq("c1_rd_en", b_en, 1'b1);
    check_eq("c1_rd_addr", b_rd_addr, 16'd0);
    tick();
    check_eq("c2_valid", b_valid, 1'b0);
    tick();
    check_eq("c3_valid", b_valid, 1'b1);
    check_eq("c3_pix", b_pix, 5'd0);
    check_eq("c3_block", b_blk, mem[0]);
    tick();
    check_eq("c4_addr_valid", b_av, 1'b1);
    check_eq("c4_out_addr", b_oaddr, 32'd0);
    repeat (20) tick();
    check_eq("hold_pix", b_pix, 5'd0);
    check_eq("hold_valid", b_valid, 1'b1);

    // One texel per 6 cycles through block (0,0)
    for (int k = 0; k < 16; k++) begin
      wf = 1'b1;
      tick();
      wf = 1'b0;
      if (k < 15) begin
        repeat (5) tick();
        check_eq("t2_pix", b_pix, k + 1);
        spec_addr = 32'hFFFF_FFFF;
        case (k + 1)
          1:  spec_addr = 32'd512;
          2:  spec_addr = 32'd1024;
          4:  spec_addr = 32'd4;
          5:  spec_addr = 32'd516;
          15: spec_addr = 32'd1548;
          default: ;
        endcase
        if (spec_addr != 32'hFFFF_FFFF) check_eq("t2_out_addr", b_oaddr, spec_addr);
      end
    end
    check_eq("gap_fetch_valid", b_valid, 1'b0);
    check_eq("gap_fetch_en", b_en, 1'b1);
    check_eq("gap_fetch_addr", b_rd_addr, 16'd1);
    wf = 1'b1;
    tick();
    check_eq("gap_wait_valid", b_valid, 1'b0);
    tick();
    wf = 1'b0;
    check_eq("blk1_valid", b_valid, 1'b1);
    check_eq("blk1_pix_noskip", b_pix, 5'd0);
    check_eq("blk1_bx", b_bx, 8'd1);
    tick();
    check_eq("blk1_out_addr", b_oaddr, 32'd16);

    // Reset in the middle of block (1,0)
    for (int i = 0; i < 7; i++) begin
      wf = 1'b1; tick();
      wf = 1'b0; tick();
    end
    check_eq("pre_rst_pix", b_pix, 5'd7);
    rst = 1'b0;
    tick();
    check_eq("rst_outs", {b_en, b_rd_addr, b_blk, b_bx, b_by, b_pix, b_valid, b_fin, b_oaddr, b_av}, '0);
    rst = 1'b1;
    repeat (3) tick();
    check_eq("restart_valid", b_valid, 1'b1);
    check_eq("restart_pix", b_pix, 5'd0);
    check_eq("restart_bx", b_bx, 8'd0);
    check_eq("restart_block", b_blk, mem[0]);

    // Random acceptance until the walk wraps to row 1
    found = 0;
    last_rd = '0;
    for (int c = 0; c < 20000 && !found; c++) begin
      wf = ($urandom_range(0, 3) != 0);
      tick();
      if (b_en) last_rd = b_rd_addr;
      if (b_valid && b_by == 8'd1) found = 1;
    end
    wf = 1'b0;
    check_eq("t3_reached", found, 1'b1);
    check_eq("t3_bx", b_bx, 8'd0);
    check_eq("t3_pix", b_pix, 5'd0);
    check_eq("t3_rd_addr", last_rd, 16'd32);
    tick();
    check_eq("t3_out_addr", b_oaddr, 32'd2048);

    repeat (300) begin
      wf = $urandom_range(0, 1);
      tick();
    end
    check_eq("small_finished", s_fin, 1'b1);
    check_eq("small_valid", s_valid, 1'b0);
    check_eq("small_rd_en", s_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
